m6502_ea_sequencer: RTL and testbench

Parametrised effective-address and operand-access sequencer for the 6502 core. It replaces the ad-hoc address-mode and load/store logic in the core with one synchronous FSM. It covers every 6502 addressing mode, load or store, ready-based wait states, the reset vector fetch and page-cross reporting. NMOS/CMOS wrap behaviour is selectable by parameter. It sits between the core's decode/execute logic and the shared memory bus.

---
 rtl/m6502_ea_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_m6502_ea_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6502_ea_sequencer.sv
// Effective-address and operand-access sequencer for the 6502 core.
// One FSM walks the operand/pointer/data bus accesses for every addressing
// mode, waits on ready, and holds the results until the next accepted start.
module m6502_ea_sequencer #(
    parameter bit          ZP_WRAP      = 1'b1,
    parameter bit          JMP_IND_BUG  = 1'b1,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        op,
    input  logic [15:0] pc,
    input  logic [7:0]  reg_x,
    input  logic [7:0]  reg_y,
    input  logic [7:0]  st_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  pc_delta,
    output logic [7:0]  ld_data,
    output logic [15:0] word_out,
    output logic [15:0] ea,
    output logic        page_cross,
    output logic [15:0] addr,
    output logic        rd_req,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    input  logic [7:0]  rd_data,
    input  logic        ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_OPLO, S_OPHI, S_PTRLO, S_PTRHI, S_DATA, S_DONE
    } state_t;

    localparam logic [3:0] M_IMPL  = 4'd0,  M_RESET = 4'd1,  M_IMM   = 4'd2;
    localparam logic [3:0] M_Z     = 4'd3,  M_Z_X   = 4'd4,  M_Z_Y   = 4'd5;
    localparam logic [3:0] M_ABS   = 4'd6,  M_ABS_X = 4'd7,  M_ABS_Y = 4'd8;
    localparam logic [3:0] M_IND_X = 4'd9,  M_IND_Y = 4'd10, M_IND_ABS = 4'd11;

    state_t      state_q, state_d;
    logic [3:0]  mode_q;
    logic        op_q;
    logic [15:0] pc_q;
    logic [7:0]  x_q, y_q, st_q;
    logic [7:0]  oplo_q, ophi_q, ptrlo_q, ptrhi_q;
    logic [7:0]  ld_q;
    logic [15:0] word_q, ea_q;
    logic        cross_q;
    logic [1:0]  delta_q;

    logic [7:0]  data_idx;
    logic [15:0] data_addr, ptr_lo_addr, ptr_hi_addr;
    logic        cross_d;

    // Zero-page sum: wraps inside page 0 on NMOS, plain 16-bit sum otherwise.
    function automatic logic [15:0] zp_sum(input logic [7:0] base, input logic [7:0] idx,
                                           input logic inc);
        logic [15:0] s;
        s = {8'h00, base} + {8'h00, idx} + {15'd0, inc};
        return ZP_WRAP ? {8'h00, s[7:0]} : s;
    endfunction

    // Operand byte count reported back to the PC logic.
    function automatic logic [1:0] delta_of(input logic [3:0] m);
        case (m)
            M_IMM, M_Z, M_Z_X, M_Z_Y, M_IND_X, M_IND_Y: return 2'd1;
            M_ABS, M_ABS_X, M_ABS_Y, M_IND_ABS:         return 2'd2;
            default:                                    return 2'd0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: each access state advances only on a ready edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (start) begin
                    if (mode == M_RESET)                         state_d = S_PTRLO;
                    else if (mode inside {[M_IMM:M_IND_ABS]})    state_d = S_OPLO;
                    else                                         state_d = S_DONE;
                end
            S_OPLO:
                if (ready) begin
                    case (mode_q)
                        M_IMM:               state_d = S_DONE;
                        M_Z, M_Z_X, M_Z_Y:   state_d = S_DATA;
                        M_IND_X, M_IND_Y:    state_d = S_PTRLO;
                        default:             state_d = S_OPHI;
                    endcase
                end
            S_OPHI:  if (ready) state_d = (mode_q == M_IND_ABS) ? S_PTRLO : S_DATA;
            S_PTRLO: if (ready) state_d = S_PTRHI;
            S_PTRHI:
                if (ready) state_d = (mode_q == M_RESET || mode_q == M_IND_ABS) ? S_DONE : S_DATA;
            S_DATA:  if (ready) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address arithmetic for pointer fetches, data access and page crossing.
    always_comb begin
        data_idx = 8'h00;
        case (mode_q)
            M_Z_X, M_ABS_X:          data_idx = x_q;
            M_Z_Y, M_ABS_Y, M_IND_Y: data_idx = y_q;
            default:                 data_idx = 8'h00;
        endcase

        case (mode_q)
            M_IMM:                   data_addr = pc_q;
            M_Z, M_Z_X, M_Z_Y:       data_addr = zp_sum(oplo_q, data_idx, 1'b0);
            M_ABS, M_ABS_X, M_ABS_Y: data_addr = {ophi_q, oplo_q} + {8'h00, data_idx};
            M_IND_X, M_IND_Y:        data_addr = {ptrhi_q, ptrlo_q} + {8'h00, data_idx};
            M_IND_ABS:               data_addr = {ophi_q, oplo_q};
            M_RESET:                 data_addr = RESET_VECTOR;
            default:                 data_addr = 16'h0000;
        endcase

        case (mode_q)
            M_ABS_X, M_ABS_Y: cross_d = (data_addr[15:8] != ophi_q);
            M_IND_Y:          cross_d = (data_addr[15:8] != ptrhi_q);
            default:          cross_d = 1'b0;
        endcase

        case (mode_q)
            M_RESET: begin
                ptr_lo_addr = RESET_VECTOR;
                ptr_hi_addr = RESET_VECTOR + 16'd1;
            end
            M_IND_X: begin
                ptr_lo_addr = zp_sum(oplo_q, x_q, 1'b0);
                ptr_hi_addr = zp_sum(oplo_q, x_q, 1'b1);
            end
            M_IND_Y: begin
                ptr_lo_addr = zp_sum(oplo_q, 8'h00, 1'b0);
                ptr_hi_addr = zp_sum(oplo_q, 8'h00, 1'b1);
            end
            default: begin
                ptr_lo_addr = {ophi_q, oplo_q};
                ptr_hi_addr = JMP_IND_BUG ? {ophi_q, oplo_q + 8'd1} : {ophi_q, oplo_q} + 16'd1;
            end
        endcase
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        addr    = 16'h0000;
        rd_req  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_OPLO:  begin addr = pc_q;          rd_req = 1'b1; end
            S_OPHI:  begin addr = pc_q + 16'd1;  rd_req = 1'b1; end
            S_PTRLO: begin addr = ptr_lo_addr;   rd_req = 1'b1; end
            S_PTRHI: begin addr = ptr_hi_addr;   rd_req = 1'b1; end
            S_DATA: begin
                addr = data_addr;
                if (op_q) begin
                    wr_en   = 1'b1;
                    wr_data = st_q;
                end else begin
                    rd_req  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch and per-access capture of operand and pointer bytes.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            mode_q <= (mode > M_IND_ABS) ? M_IMPL : mode;
            op_q   <= op;
            pc_q   <= pc;
            x_q    <= reg_x;
            y_q    <= reg_y;
            st_q   <= st_data;
        end
        if (ready) begin
            case (state_q)
                S_OPLO:  oplo_q  <= rd_data;
                S_OPHI:  ophi_q  <= rd_data;
                S_PTRLO: ptrlo_q <= rd_data;
                S_PTRHI: ptrhi_q <= rd_data;
                default: ;
            endcase
        end
    end

    // Result registers: cleared on start, filled as accesses complete.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_q    <= 8'h00;
            word_q  <= 16'h0000;
            ea_q    <= 16'h0000;
            cross_q <= 1'b0;
            delta_q <= 2'd0;
        end else begin
            if (state_q == S_IDLE && start) begin
                ld_q    <= 8'h00;
                word_q  <= 16'h0000;
                ea_q    <= 16'h0000;
                cross_q <= 1'b0;
                delta_q <= delta_of(mode);
            end
            if (ready && state_q == S_OPLO && mode_q == M_IMM) ld_q <= rd_data;
            if (ready && state_q == S_DATA && !op_q)           ld_q <= rd_data;
            if (ready && state_q == S_PTRHI && (mode_q == M_RESET || mode_q == M_IND_ABS))
                word_q <= {rd_data, ptrlo_q};
            if (state_q != S_IDLE && state_q != S_DONE && state_d == S_DONE) begin
                ea_q    <= data_addr;
                cross_q <= cross_d;
            end
        end
    end

    assign ld_data    = ld_q;
    assign word_out   = word_q;
    assign ea         = ea_q;
    assign page_cross = cross_q;
    assign pc_delta   = delta_q;

endmodule

// File: tb/tb_m6502_ea_sequencer.sv
// Scoreboard bench: two sequencers (NMOS-style and CMOS-style parameters)
// share stimulus and a memory image; a reference model predicts each bus
// access and the final results, and per-instance monitors compare them.
module tb_m6502_ea_sequencer;

    localparam int RV = 'hFFFC;

    typedef struct { int a; int w; int d; } acc_t;
    typedef struct {
        int start; int lat;
        int ld; int ld_chk; int word; int word_chk;
        int ea; int ea_chk; int pcross; int delta;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic        op = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  reg_x = 8'h00, reg_y = 8'h00, st_data = 8'h00;

    logic [7:0]  mem [0:65535];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          wait_mode = 0;
    acc_t        mq[$];
    res_t        mr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
    endtask

    function automatic int rdm(input int a);
        logic [15:0] i;
        i = a[15:0];
        return int'(mem[i]);
    endfunction

    task automatic acc(input int a, input int w, input int d);
        acc_t e;
        e.a = a; e.w = w; e.d = d;
        mq.push_back(e);
    endtask

    // Reference model: the 6502 addressing rules written as integer arithmetic.
    task automatic model(input bit zw, input bit jb, input int m, input int o, input int p,
                         input int x, input int y, input int sd, input int w, input int st);
        int base, a, zp, lo_a, hi_a, idx, data;
        mq.delete();
        mr = '{default: 0};
        mr.start = st; mr.ea_chk = 1; data = 0; a = 0;
        idx = (m == 4 || m == 7) ? x : ((m == 5 || m == 8 || m == 10) ? y : 0);
        case (m)
            1: begin
                acc(RV, 0, 0); acc((RV + 1) % 65536, 0, 0);
                mr.word = rdm(RV) + 256 * rdm((RV + 1) % 65536); mr.word_chk = 1; mr.ea = RV;
            end
            2: begin
                acc(p, 0, 0); mr.ld = rdm(p); mr.ld_chk = 1; mr.ea = p; mr.delta = 1;
            end
            3, 4, 5: begin
                acc(p, 0, 0); zp = rdm(p);
                a = zw ? (zp + idx) % 256 : zp + idx; data = 1; mr.delta = 1;
            end
            6, 7, 8: begin
                acc(p, 0, 0); acc((p + 1) % 65536, 0, 0);
                base = rdm(p) + 256 * rdm((p + 1) % 65536);
                a = (base + idx) % 65536; mr.pcross = (m != 6 && a / 256 != base / 256) ? 1 : 0;
                data = 1; mr.delta = 2;
            end
            9, 10: begin
                acc(p, 0, 0); zp = rdm(p);
                if (m == 9) zp = zp + x;
                lo_a = zw ? zp % 256 : zp;
                hi_a = zw ? (zp + 1) % 256 : zp + 1;
                acc(lo_a, 0, 0); acc(hi_a, 0, 0);
                base = rdm(lo_a) + 256 * rdm(hi_a);
                a = (base + idx) % 65536;
                mr.pcross = (m == 10 && a / 256 != base / 256) ? 1 : 0;
                data = 1; mr.delta = 1;
            end
            11: begin
                acc(p, 0, 0); acc((p + 1) % 65536, 0, 0);
                base = rdm(p) + 256 * rdm((p + 1) % 65536);
                hi_a = jb ? (base / 256) * 256 + (base % 256 + 1) % 256 : (base + 1) % 65536;
                acc(base, 0, 0); acc(hi_a, 0, 0);
                mr.word = rdm(base) + 256 * rdm(hi_a); mr.word_chk = 1;
                mr.ea = base; mr.delta = 2;
            end
            default: mr.ea_chk = 0;
        endcase
        if (data != 0) begin
            mr.ea = a;
            if (o != 0) acc(a, 1, sd);
            else begin acc(a, 0, 0); mr.ld = rdm(a); mr.ld_chk = 1; end
        end
        mr.lat = (w < 0) ? -1 : mq.size() * (w + 1) + 1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        logic        busy, done, page_cross, rd_req, wr_en;
        logic [1:0]  pc_delta;
        logic [7:0]  ld_data, wr_data;
        logic [7:0]  rd_data = 8'h00;
        logic        ready = 1'b0;
        logic [15:0] word_out, ea, addr;
        wire  [70:0] all_out = {busy, done, pc_delta, ld_data, word_out, ea, page_cross,
                                addr, rd_req, wr_en, wr_data};
        acc_t        accq[$];
        res_t        resq[$];

        m6502_ea_sequencer #(
            .ZP_WRAP((g == 0) ? 1'b1 : 1'b0),
            .JMP_IND_BUG((g == 0) ? 1'b1 : 1'b0),
            .RESET_VECTOR(16'hFFFC)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .op(op), .pc(pc),
            .reg_x(reg_x), .reg_y(reg_y), .st_data(st_data),
            .busy(busy), .done(done), .pc_delta(pc_delta), .ld_data(ld_data),
            .word_out(word_out), .ea(ea), .page_cross(page_cross),
            .addr(addr), .rd_req(rd_req), .wr_en(wr_en), .wr_data(wr_data),
            .rd_data(rd_data), .ready(ready)
        );

        // Bus responder and access monitor.
        int          wcnt = 0;
        bit          pend = 1'b0, stall = 1'b0;
        logic [15:0] s_addr;
        logic        s_rd, s_wr;
        logic [7:0]  s_wd;
        acc_t        e;
        always begin
            @(negedge clk);
            #2;
            if (pend) begin
                if (accq.size() == 0) fail($sformatf("g%0d unexpected_access", g));
                else begin
                    e = accq.pop_front();
                    chk($sformatf("g%0d acc_addr", g), int'(s_addr), e.a);
                    chk($sformatf("g%0d acc_is_write", g), int'(s_wr), e.w);
                    if (e.w != 0) chk($sformatf("g%0d acc_wdata", g), int'(s_wd), e.d);
                end
            end
            if (stall)
                chk($sformatf("g%0d bus_stable", g),
                    int'({addr, rd_req, wr_en, wr_data} == {s_addr, s_rd, s_wr, s_wd}), 1);
            pend = 1'b0; stall = 1'b0;
            if (!reset_n) begin
                ready = 1'b0; wcnt = 0;
            end else if (rd_req || wr_en) begin
                chk($sformatf("g%0d rd_and_wr", g), int'(rd_req && wr_en), 0);
                ready   = (wait_mode < 0) ? ($urandom_range(0, 3) != 0) : (wcnt >= wait_mode);
                rd_data = mem[addr];
                s_addr = addr; s_rd = rd_req; s_wr = wr_en; s_wd = wr_data;
                pend  = ready;
                stall = !ready;
                wcnt  = ready ? 0 : wcnt + 1;
            end else begin
                ready   = ($urandom_range(0, 1) != 0);
                rd_data = 8'($urandom);
                wcnt    = 0;
            end
        end

        // Completion monitor.
        res_t r;
        always begin
            @(negedge clk);
            #2;
            if (done) begin
                if (resq.size() == 0) fail($sformatf("g%0d unexpected_done", g));
                else begin
                    r = resq.pop_front();
                    if (r.lat >= 0) chk($sformatf("g%0d done_latency", g), cyc - r.start, r.lat);
                    chk($sformatf("g%0d pc_delta", g), int'(pc_delta), r.delta);
                    chk($sformatf("g%0d page_cross", g), int'(page_cross), r.pcross);
                    if (r.ea_chk != 0)   chk($sformatf("g%0d ea", g), int'(ea), r.ea);
                    if (r.ld_chk != 0)   chk($sformatf("g%0d ld_data", g), int'(ld_data), r.ld);
                    if (r.word_chk != 0) chk($sformatf("g%0d word_out", g), int'(word_out), r.word);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((gi[0].busy || gi[1].busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail("idle_timeout");
    endtask

    task automatic issue(input logic [3:0] m, input logic o, input logic [15:0] p,
                         input logic [7:0] x, input logic [7:0] y, input logic [7:0] sd,
                         input int w);
        wait_idle();
        wait_mode = w;
        model(1'b1, 1'b1, int'(m), int'(o), int'(p), int'(x), int'(y), int'(sd), w, cyc);
        foreach (mq[i]) gi[0].accq.push_back(mq[i]);
        gi[0].resq.push_back(mr);
        model(1'b0, 1'b0, int'(m), int'(o), int'(p), int'(x), int'(y), int'(sd), w, cyc);
        foreach (mq[i]) gi[1].accq.push_back(mq[i]);
        gi[1].resq.push_back(mr);
        mode = m; op = o; pc = p; reg_x = x; reg_y = y; st_data = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 4'($urandom); op = 1'($urandom); pc = 16'($urandom);
        reg_x = 8'($urandom); reg_y = 8'($urandom); st_data = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk("reset_outputs g0", int'(gi[0].all_out == '0), 1);
        chk("reset_outputs g1", int'(gi[1].all_out == '0), 1);
        reset_n = 1'b1;

        // Reset vector fetch.
        wait_idle();
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
        issue(4'd1, 1'b1, 16'h1234, 8'h00, 8'h00, 8'h00, 0);

        // Zero-page indexed load with and without page-0 wrap.
        wait_idle();
        mem[16'h0200] = 8'hF0; mem[16'h0010] = 8'h5A; mem[16'h0110] = 8'h77;
        issue(4'd4, 1'b0, 16'h0200, 8'h20, 8'h00, 8'h00, 0);

        // Absolute,Y with and without a page cross.
        wait_idle();
        mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12; mem[16'h1300] = 8'h3C;
        issue(4'd8, 1'b0, 16'h0300, 8'h00, 8'h01, 8'h00, 0);
        issue(4'd8, 1'b0, 16'h0300, 8'h00, 8'h00, 8'h00, 0);

        // (zp),Y store with two wait cycles per access.
        wait_idle();
        mem[16'h0400] = 8'h40; mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h20;
        issue(4'd10, 1'b1, 16'h0400, 8'h00, 8'h05, 8'hA7, 2);

        // Indirect jump pointer at a page end.
        wait_idle();
        mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
        mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h56;
        issue(4'd11, 1'b0, 16'h0500, 8'h00, 8'h00, 8'h00, 0);

        // (zp,X) with the pointer straddling the zero-page end; implied modes.
        wait_idle();
        mem[16'h0600] = 8'hFE;
        issue(4'd9, 1'b0, 16'h0600, 8'h01, 8'h00, 8'h00, -1);
        issue(4'd0, 1'b0, 16'h0700, 8'h00, 8'h00, 8'h00, 0);
        issue(4'd13, 1'b1, 16'h0700, 8'h00, 8'h00, 8'h00, 0);

        // A start while busy must be ignored.
        issue(4'd9, 1'b0, 16'h0600, 8'h10, 8'h00, 8'h00, 2);
        @(negedge clk);
        chk("busy_during_op g0", int'(gi[0].busy), 1);
        chk("busy_during_op g1", int'(gi[1].busy), 1);
        mode = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset while the pointer high byte is on the bus.
        wait_idle();
        issue(4'd10, 1'b0, 16'h0400, 8'h00, 8'h05, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        chk("ptrhi_addr g0", int'(gi[0].addr), 'h0041);
        chk("ptrhi_addr g1", int'(gi[1].addr), 'h0041);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs g0", int'(gi[0].all_out == '0), 1);
        chk("abort_outputs g1", int'(gi[1].all_out == '0), 1);
        reset_n = 1'b1;
        gi[0].accq.delete(); gi[0].resq.delete();
        gi[1].accq.delete(); gi[1].resq.delete();
        issue(4'd2, 1'b0, 16'h0801, 8'h00, 8'h00, 8'h00, 0);

        // Randomized traffic across all modes and wait policies.
        for (int t = 0; t < 80; t++)
            issue(4'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), int'($urandom_range(0, 3)) - 1);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("acc_queue_drained g0", gi[0].accq.size(), 0);
        chk("acc_queue_drained g1", gi[1].accq.size(), 0);
        chk("res_queue_drained g0", gi[0].resq.size(), 0);
        chk("res_queue_drained g1", gi[1].resq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
